// File: rtl/facto_core_gen.sv
// ============================================================================
// facto_core_gen
// ----------------------------------------------------------------------------
// Memory-mapped factorial accelerator. Software loads OPERAND, writes 1 to
// OPSTART and the core computes OPERAND! with an internal shift-add
// multiplier. The 2W-bit result is exposed as RESULT_H:RESULT_L. Completion
// (and overflow) is reported in OPDONE. It can also raise `interrupt`.
//
// Parameters
//   W               operand / bus data width (even, >= 8); result is 2W bits
//
// Build options
//   FACTO_RADIX4_EN when defined, the multiplier retires two multiplier bits
//                   per cycle (W/2 MUL cycles per iteration) instead of one.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   s_sel      in   slave select from the upstream address decoder
//   s_wr       in   1 = write, 0 = read (qualified by s_sel)
//   s_addr     in   byte address, register index = s_addr[5:3]
//   s_din      in   write data (W bits)
//   s_dout     out  combinational read data, 0 when not reading
//   interrupt  out  OPDONE[0] & INTREN[0]
//
// Register map (index = s_addr[5:3])
//   0 OPSTART  (W/O, reads 0)    4 OPERAND  (R/W, locked while busy)
//   1 OPCLEAR  (R/W)             5 RESULT_H (R/O)
//   2 OPDONE   (R/O) {ovf,done}  6 RESULT_L (R/O)
//   3 INTREN   (R/W)             7 STATUS   (R/O) {W[7:0],6'b0,ovf,busy}
// ============================================================================
module facto_core_gen #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_sel,
    input  logic         s_wr,
    input  logic [15:0]  s_addr,
    input  logic [W-1:0] s_din,
    output logic [W-1:0] s_dout,
    output logic         interrupt
);

`ifdef FACTO_RADIX4_EN
    localparam int STEPS = W / 2;
    localparam int SHIFT = 2;
`else
    localparam int STEPS = W;
    localparam int SHIFT = 1;
`endif
    localparam int              CW        = $clog2(STEPS) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(STEPS - 1);
    localparam logic [W-1:0]    ONE       = W'(1);
    localparam logic [W-1:0]    TWO       = W'(2);
    localparam int              SW        = (W < 16) ? 16 : W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_UPD   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] IDX_OPSTART  = 3'd0;
    localparam logic [2:0] IDX_OPCLEAR  = 3'd1;
    localparam logic [2:0] IDX_OPDONE   = 3'd2;
    localparam logic [2:0] IDX_INTREN   = 3'd3;
    localparam logic [2:0] IDX_OPERAND  = 3'd4;
    localparam logic [2:0] IDX_RESULT_H = 3'd5;
    localparam logic [2:0] IDX_RESULT_L = 3'd6;
    localparam logic [2:0] IDX_STATUS   = 3'd7;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]     state_q,    state_d;
    logic [W-1:0]   opclear_q,  opclear_d;
    logic [W-1:0]   intren_q,   intren_d;
    logic [W-1:0]   operand_q,  operand_d;
    logic [1:0]     opdone_q,   opdone_d;
    logic [W-1:0]   result_h_q, result_h_d;
    logic [W-1:0]   result_l_q, result_l_d;
    logic [W-1:0]   cnt_q,      cnt_d;
    logic [W-1:0]   fac_q,      fac_d;
    logic           ovf_q,      ovf_d;
    logic [2*W-1:0] mcand_q,    mcand_d;
    logic [W-1:0]   mplier_q,   mplier_d;
    logic [2*W-1:0] acc_q,      acc_d;
    logic [CW-1:0]  step_q,     step_d;

    logic [2:0]     reg_idx;
    logic           bus_wr;
    logic           busy;
    logic           clear_active;
    logic           start_req;
    logic [2*W-1:0] pp;
    logic [SW-1:0]  status_wide;
    logic           unused_addr_bits;

    assign reg_idx          = s_addr[5:3];
    assign bus_wr           = s_sel & s_wr;
    assign busy             = (state_q != S_IDLE);
    assign unused_addr_bits = ^{s_addr[15:6], s_addr[2:0]};

    // ------------------------------------------------------------------
    // Partial product for one MUL cycle. The multiplicand register is
    // already shifted to the weight of the current multiplier bit(s).
    // ------------------------------------------------------------------
    always_comb begin
        pp = '0;
`ifdef FACTO_RADIX4_EN
        if (mplier_q[0]) pp = mcand_q;
        if (mplier_q[1]) pp = pp + {mcand_q[2*W-2:0], 1'b0};
`else
        if (mplier_q[0]) pp = mcand_q;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic: register writes, clear handling and the FSM.
    //
    // The clear is keyed off the next value of OPCLEAR so that a write
    // of 1 takes effect on its own edge: from the following cycle the
    // core is idle with OPDONE=0 and RESULT=1, and it stays that way
    // until software writes OPCLEAR back to 0.
    //
    // Factors are applied in ascending order (2, 3, ..., N) while cnt
    // counts the remaining iterations down. Every intermediate is then
    // a true k!, so overflow is flagged exactly when some k! < N! no
    // longer fits in W bits before it would be multiplied again.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        opclear_d  = opclear_q;
        intren_d   = intren_q;
        operand_d  = operand_q;
        opdone_d   = opdone_q;
        result_h_d = result_h_q;
        result_l_d = result_l_q;
        cnt_d      = cnt_q;
        fac_d      = fac_q;
        ovf_d      = ovf_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        step_d     = step_q;

        if (bus_wr && reg_idx == IDX_OPCLEAR) opclear_d = s_din;
        if (bus_wr && reg_idx == IDX_INTREN)  intren_d  = s_din;
        if (bus_wr && reg_idx == IDX_OPERAND && !busy) operand_d = s_din;

        clear_active = opclear_d[0];
        start_req    = bus_wr && (reg_idx == IDX_OPSTART) && s_din[0];

        if (clear_active) begin
            state_d    = S_IDLE;
            opdone_d   = 2'b00;
            result_h_d = '0;
            result_l_d = ONE;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_d    = S_CHECK;
                        result_h_d = '0;
                        result_l_d = ONE;
                        cnt_d      = operand_q;
                        fac_d      = TWO;
                        opdone_d   = 2'b00;
                        ovf_d      = 1'b0;
                    end
                end
                S_CHECK: begin
                    if (cnt_q <= ONE) begin
                        state_d = S_DONE;
                    end else if (result_h_q != '0) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mcand_d  = {{W{1'b0}}, result_l_q};
                        mplier_d = fac_q;
                        acc_d    = '0;
                        step_d   = '0;
                        state_d  = S_MUL;
                    end
                end
                S_MUL: begin
                    acc_d    = acc_q + pp;
                    mcand_d  = mcand_q << SHIFT;
                    mplier_d = mplier_q >> SHIFT;
                    step_d   = step_q + CW'(1);
                    if (step_q == LAST_STEP) state_d = S_UPD;
                end
                S_UPD: begin
                    {result_h_d, result_l_d} = acc_q;
                    cnt_d   = cnt_q - ONE;
                    fac_d   = fac_q + ONE;
                    state_d = S_CHECK;
                end
                S_DONE: begin
                    opdone_d = {ovf_q, 1'b1};
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers with asynchronous active-low reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            opclear_q  <= '0;
            intren_q   <= '0;
            operand_q  <= '0;
            opdone_q   <= 2'b00;
            result_h_q <= '0;
            result_l_q <= ONE;
            cnt_q      <= '0;
            fac_q      <= '0;
            ovf_q      <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            opclear_q  <= opclear_d;
            intren_q   <= intren_d;
            operand_q  <= operand_d;
            opdone_q   <= opdone_d;
            result_h_q <= result_h_d;
            result_l_q <= result_l_d;
            cnt_q      <= cnt_d;
            fac_q      <= fac_d;
            ovf_q      <= ovf_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
        end
    end

    // ------------------------------------------------------------------
    // STATUS is assembled 16 bits wide at minimum so the width field
    // fits; for W=8 only the low byte is visible on the bus.
    // ------------------------------------------------------------------
    always_comb begin
        status_wide       = '0;
        status_wide[0]    = busy;
        status_wide[1]    = ovf_q;
        status_wide[15:8] = 8'(W);
    end

    // Combinational read mux; the bus reads 0 unless a read is selected.
    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (reg_idx)
                IDX_OPSTART:  s_dout = '0;
                IDX_OPCLEAR:  s_dout = opclear_q;
                IDX_OPDONE:   s_dout = {{(W-2){1'b0}}, opdone_q};
                IDX_INTREN:   s_dout = intren_q;
                IDX_OPERAND:  s_dout = operand_q;
                IDX_RESULT_H: s_dout = result_h_q;
                IDX_RESULT_L: s_dout = result_l_q;
                IDX_STATUS:   s_dout = status_wide[W-1:0];
            endcase
        end
    end

    assign interrupt = opdone_q[0] & intren_q[0];

endmodule

// File: tb/tb_facto_core_gen.sv
// ============================================================================
// tb_facto_core_gen
// ----------------------------------------------------------------------------
// Directed testbench for facto_core_gen. Two instances are exercised: a
// 64-bit core (A) and a 16-bit core (B). Expected results are hand-computed
// factorials; latencies use the per-iteration cost of the build.
// ============================================================================
module tb_facto_core_gen;

    localparam int WA = 64;
    localparam int WB = 16;
`ifdef FACTO_RADIX4_EN
    localparam int ITER_A = WA / 2 + 2;
    localparam int ITER_B = WB / 2 + 2;
`else
    localparam int ITER_A = WA + 2;
    localparam int ITER_B = WB + 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sel_a, wr_a, irq_a;
    logic [15:0]   addr_a;
    logic [WA-1:0] din_a, dout_a;
    logic          sel_b, wr_b, irq_b;
    logic [15:0]   addr_b;
    logic [WB-1:0] din_b, dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    facto_core_gen #(.W(WA)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_sel(sel_a), .s_wr(wr_a),
        .s_addr(addr_a), .s_din(din_a), .s_dout(dout_a), .interrupt(irq_a)
    );

    facto_core_gen #(.W(WB)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_sel(sel_b), .s_wr(wr_b),
        .s_addr(addr_b), .s_din(din_b), .s_dout(dout_b), .interrupt(irq_b)
    );

    // Bus access helpers: a write is presented at the falling edge and
    // retired by the next rising edge; reads are taken mid-cycle.
    task automatic write_a(input int idx, input logic [WA-1:0] d);
        @(negedge clk);
        sel_a = 1'b1; wr_a = 1'b1; addr_a = 16'(idx * 8); din_a = d;
        @(posedge clk); #1;
        sel_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic read_a(input int idx, output logic [WA-1:0] d);
        sel_a = 1'b1; wr_a = 1'b0; addr_a = 16'(idx * 8);
        #1;
        d = dout_a;
        sel_a = 1'b0;
    endtask

    task automatic write_b(input int idx, input logic [WB-1:0] d);
        @(negedge clk);
        sel_b = 1'b1; wr_b = 1'b1; addr_b = 16'(idx * 8); din_b = d;
        @(posedge clk); #1;
        sel_b = 1'b0; wr_b = 1'b0;
    endtask

    task automatic read_b(input int idx, output logic [WB-1:0] d);
        sel_b = 1'b1; wr_b = 1'b0; addr_b = 16'(idx * 8);
        #1;
        d = dout_b;
        sel_b = 1'b0;
    endtask

    // Counts rising edges after the start edge until OPDONE[0] is seen;
    // -1 when the cycle budget runs out.
    task automatic wait_done_a(output int edges);
        logic [WA-1:0] v;
        edges = -1;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk); #1;
            read_a(2, v);
            if (v[0]) begin edges = k; break; end
        end
    endtask

    task automatic wait_done_b(output int edges);
        logic [WB-1:0] v;
        edges = -1;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk); #1;
            read_b(2, v);
            if (v[0]) begin edges = k; break; end
        end
    endtask

    task automatic test_reset;
        logic [WA-1:0] va;
        logic [WB-1:0] vb;
        logic [WA-1:0] exp_a [8];
        logic [WB-1:0] exp_b [8];
        exp_a = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h1, 64'h4000};
        exp_b = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1, 16'h1000};
        reset_n = 1'b0;
        #12;
        checks++;
        if (dout_a !== '0) begin errors++; $display("[TB] FAIL reset_dout_idle: got %h expected 0", dout_a); end
        for (int i = 0; i < 8; i++) begin
            read_a(i, va);
            checks++;
            if (va !== exp_a[i]) begin errors++; $display("[TB] FAIL reset_a_reg%0d: got %h expected %h", i, va, exp_a[i]); end
            read_b(i, vb);
            checks++;
            if (vb !== exp_b[i]) begin errors++; $display("[TB] FAIL reset_b_reg%0d: got %h expected %h", i, vb, exp_b[i]); end
        end
        checks++;
        if (irq_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq_a); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_register_access;
        logic [WA-1:0] v;
        write_a(6, 64'hDEAD_BEEF);
        read_a(6, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL ro_result_l: got %h expected 1", v); end
        write_a(2, 64'h3);
        read_a(2, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL ro_opdone: got %h expected 0", v); end
        write_a(0, 64'h2);
        read_a(7, v);
        checks++;
        if (v !== 64'h4000) begin errors++; $display("[TB] FAIL start_bit0_zero: got %h expected 4000", v); end
        write_a(3, 64'h1);
        read_a(3, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL intren_rw: got %h expected 1", v); end
    endtask

    task automatic test_factorial_5;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd5);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e !== 4 * ITER_A + 2) begin errors++; $display("[TB] FAIL fact5_latency: got %0d expected %0d", e, 4 * ITER_A + 2); end
        checks++;
        if (irq_a !== 1'b1) begin errors++; $display("[TB] FAIL fact5_irq: got %b expected 1", irq_a); end
        read_a(6, v);
        checks++;
        if (v !== 64'h78) begin errors++; $display("[TB] FAIL fact5_result_l: got %h expected 78", v); end
        read_a(5, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL fact5_result_h: got %h expected 0", v); end
        read_a(2, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL fact5_opdone: got %h expected 1", v); end
        write_a(3, 64'h0);
        checks++;
        if (irq_a !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked: got %b expected 0", irq_a); end
    endtask

    task automatic test_small_operands;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd0);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e !== 2) begin errors++; $display("[TB] FAIL op0_latency: got %0d expected 2", e); end
        read_a(6, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL op0_result: got %h expected 1", v); end
        write_a(4, 64'd1);
        write_a(0, 64'h1);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e + 1 !== 2) begin errors++; $display("[TB] FAIL op1_latency: got %0d expected 2", e + 1); end
        read_a(2, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL op1_opdone: got %h expected 1", v); end
    endtask

    task automatic test_busy_lock;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd5);
        write_a(0, 64'h1);
        write_a(0, 64'h1);
        write_a(4, 64'd3);
        read_a(4, v);
        checks++;
        if (v !== 64'd5) begin errors++; $display("[TB] FAIL busy_operand_lock: got %h expected 5", v); end
        read_a(7, v);
        checks++;
        if (v !== 64'h4001) begin errors++; $display("[TB] FAIL busy_status: got %h expected 4001", v); end
        wait_done_a(e);
        checks++;
        if (e + 2 !== 4 * ITER_A + 2) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", e + 2, 4 * ITER_A + 2); end
        read_a(6, v);
        checks++;
        if (v !== 64'h78) begin errors++; $display("[TB] FAIL busy_result: got %h expected 78", v); end
    endtask

    task automatic test_overflow_64;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd21);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e !== 20 * ITER_A + 2) begin errors++; $display("[TB] FAIL f21_latency: got %0d expected %0d", e, 20 * ITER_A + 2); end
        read_a(5, v);
        checks++;
        if (v !== 64'h2) begin errors++; $display("[TB] FAIL f21_result_h: got %h expected 2", v); end
        read_a(6, v);
        checks++;
        if (v !== 64'hC5077D36B8C40000) begin errors++; $display("[TB] FAIL f21_result_l: got %h expected c5077d36b8c40000", v); end
        read_a(2, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL f21_opdone: got %h expected 1", v); end
        write_a(4, 64'd22);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e !== 20 * ITER_A + 2) begin errors++; $display("[TB] FAIL f22_latency: got %0d expected %0d", e, 20 * ITER_A + 2); end
        read_a(2, v);
        checks++;
        if (v !== 64'h3) begin errors++; $display("[TB] FAIL f22_opdone: got %h expected 3", v); end
        read_a(7, v);
        checks++;
        if (v !== 64'h4002) begin errors++; $display("[TB] FAIL f22_status: got %h expected 4002", v); end
        read_a(6, v);
        checks++;
        if (v !== 64'hC5077D36B8C40000) begin errors++; $display("[TB] FAIL f22_last_valid: got %h expected c5077d36b8c40000", v); end
    endtask

    task automatic test_w16;
        logic [WB-1:0] v;
        int e;
        write_b(4, 16'd9);
        write_b(0, 16'h1);
        wait_done_b(e);
        checks++;
        if (e !== 8 * ITER_B + 2) begin errors++; $display("[TB] FAIL w16_f9_latency: got %0d expected %0d", e, 8 * ITER_B + 2); end
        read_b(5, v);
        checks++;
        if (v !== 16'h0005) begin errors++; $display("[TB] FAIL w16_f9_result_h: got %h expected 0005", v); end
        read_b(6, v);
        checks++;
        if (v !== 16'h8980) begin errors++; $display("[TB] FAIL w16_f9_result_l: got %h expected 8980", v); end
        write_b(4, 16'd10);
        write_b(0, 16'h1);
        wait_done_b(e);
        read_b(2, v);
        checks++;
        if (v !== 16'h3) begin errors++; $display("[TB] FAIL w16_f10_opdone: got %h expected 3", v); end
        read_b(6, v);
        checks++;
        if (v !== 16'h8980) begin errors++; $display("[TB] FAIL w16_f10_last_valid: got %h expected 8980", v); end
    endtask

    task automatic test_back_to_back;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd3);
        write_a(0, 64'h1);
        wait_done_a(e);
        write_a(4, 64'd4);
        write_a(0, 64'h1);
        read_a(2, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL b2b_opdone_cleared: got %h expected 0", v); end
        wait_done_a(e);
        checks++;
        if (e !== 3 * ITER_A + 2) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", e, 3 * ITER_A + 2); end
        read_a(6, v);
        checks++;
        if (v !== 64'h18) begin errors++; $display("[TB] FAIL b2b_result: got %h expected 18", v); end
    endtask

    task automatic test_clear;
        logic [WA-1:0] v;
        int e;
        write_a(4, 64'd5);
        write_a(0, 64'h1);
        repeat (2 * ITER_A + 5) @(posedge clk);
        #1;
        read_a(6, v);
        checks++;
        if (v !== 64'h6) begin errors++; $display("[TB] FAIL clr_partial: got %h expected 6", v); end
        write_a(1, 64'h1);
        read_a(7, v);
        checks++;
        if (v !== 64'h4000) begin errors++; $display("[TB] FAIL clr_status: got %h expected 4000", v); end
        read_a(2, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL clr_opdone: got %h expected 0", v); end
        read_a(6, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL clr_result_l: got %h expected 1", v); end
        read_a(1, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL clr_readback: got %h expected 1", v); end
        write_a(0, 64'h1);
        repeat (3) @(posedge clk);
        #1;
        read_a(7, v);
        checks++;
        if (v !== 64'h4000) begin errors++; $display("[TB] FAIL clr_start_ignored: got %h expected 4000", v); end
        write_a(1, 64'h0);
        write_a(4, 64'd3);
        write_a(0, 64'h1);
        wait_done_a(e);
        checks++;
        if (e !== 2 * ITER_A + 2) begin errors++; $display("[TB] FAIL clr_f3_latency: got %0d expected %0d", e, 2 * ITER_A + 2); end
        read_a(6, v);
        checks++;
        if (v !== 64'h6) begin errors++; $display("[TB] FAIL clr_f3_result: got %h expected 6", v); end
    endtask

    task automatic test_reset_mid;
        logic [WA-1:0] v;
        write_a(3, 64'h1);
        write_a(4, 64'd5);
        write_a(0, 64'h1);
        repeat (100) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        read_a(7, v);
        checks++;
        if (v !== 64'h4000) begin errors++; $display("[TB] FAIL rmid_status: got %h expected 4000", v); end
        read_a(4, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL rmid_operand: got %h expected 0", v); end
        read_a(3, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("[TB] FAIL rmid_intren: got %h expected 0", v); end
        read_a(6, v);
        checks++;
        if (v !== 64'h1) begin errors++; $display("[TB] FAIL rmid_result_l: got %h expected 1", v); end
        checks++;
        if (irq_a !== 1'b0) begin errors++; $display("[TB] FAIL rmid_irq: got %b expected 0", irq_a); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        sel_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
        sel_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        test_reset;
        test_register_access;
        test_factorial_5;
        test_small_operands;
        test_busy_lock;
        test_overflow_64;
        test_w16;
        test_back_to_back;
        test_clear;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
